// File: rtl/tft_pkg.sv
// tft_pkg: shared definitions for the TFT timing blocks.
// Holds the sync-decoder FSM encoding, the default 480x272 panel geometry,
// the counter widths shared with the timing generator, and small helpers.
package tft_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  // Default panel geometry (active area).
  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_V_ACTIVE = 272;

  // Counter widths shared with the timing generator.
  localparam int PIX_W  = 10;  // pixel column / row
  localparam int HTOT_W = 11;  // clocks per line
  localparam int VTOT_W = 10;  // lines per frame
  localparam int STAT_W = 16;  // optional statistics counters
  localparam int GOOD_W = 8;   // good-frame counter used while aligning

  // Registered level of one timing input plus its edge pulses.
  typedef struct packed {
    logic level;  // asserted (polarity already normalized)
    logic lead;   // transition into the asserted level
    logic trail;  // transition out of the asserted level
  } edge_t;

  function automatic logic [HTOT_W-1:0] sat_inc_h(input logic [HTOT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PIX_W-1:0] sat_inc_p(input logic [PIX_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tft_edge_detect.sv
// tft_edge_detect: registers one timing input, normalizes its polarity so
// that 1 means asserted, and derives leading/trailing edge pulses from the
// registered sample and its previous value.
module tft_edge_detect
  import tft_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  raw,
  output edge_t ev
);

  logic cur;
  logic prev;

  // Sample the normalized input and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= raw ^ ACTIVE_LOW;
      prev <= cur;
    end
  end

  assign ev.level = cur;
  assign ev.lead  = cur & ~prev;
  assign ev.trail = ~cur & prev;

endmodule

// File: rtl/tft_sync_decoder.sv
// tft_sync_decoder: decodes a DE/HSYNC/VSYNC panel timing stream into pixel
// coordinates, measures line/frame geometry and tracks lock to the expected
// active area. Optional statistics counters are built when the macro
// TFT_SYNC_DECODER_STATS_EN is defined.
module tft_sync_decoder
  import tft_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic              in_9mhz_clk,
  input  logic              in_rst,
  input  logic              in_en,
  input  logic              in_hsync,
  input  logic              in_vsync,
  output logic              out_valid,
  output logic [PIX_W-1:0]  out_pixelx,
  output logic [PIX_W-1:0]  out_pixely,
  output logic              out_sof,
  output logic              out_locked,
  output logic              out_err,
  output logic [HTOT_W-1:0] out_h_total,
  output logic [VTOT_W-1:0] out_v_total
`ifdef TFT_SYNC_DECODER_STATS_EN
  ,
  output logic [STAT_W-1:0] out_frame_cnt,
  output logic [STAT_W-1:0] out_err_cnt
`endif
);

  edge_t en_ev, hs_ev, vs_ev;

  tft_edge_detect #(.ACTIVE_LOW(1'b0)) u_en (
    .clk(in_9mhz_clk), .rst(in_rst), .raw(in_en), .ev(en_ev));
  tft_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs (
    .clk(in_9mhz_clk), .rst(in_rst), .raw(in_hsync), .ev(hs_ev));
  tft_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs (
    .clk(in_9mhz_clk), .rst(in_rst), .raw(in_vsync), .ev(vs_ev));

  logic [HTOT_W-1:0] x_cnt;     // pixels seen so far in the current line
  logic [HTOT_W-1:0] h_cnt;     // clocks since the last hsync leading edge
  logic [PIX_W-1:0]  y_cnt;     // DE lines seen so far in the current frame
  logic              armed;     // a vsync has been seen since reset
  sync_state_t       state;
  logic [GOOD_W-1:0] good_cnt;

  logic [HTOT_W-1:0] col;
  logic [PIX_W-1:0]  lines;
  logic              err_now;

  logic unused_ev;
  assign unused_ev = ^{hs_ev.level, hs_ev.trail, vs_ev.trail};

  // Current pixel column, line count including a line ending now, and the
  // geometry checks. Checks stay quiet until the first vsync after reset so
  // a truncated line or frame is never reported.
  always_comb begin
    col     = en_ev.lead ? '0 : x_cnt;
    lines   = en_ev.trail ? sat_inc_p(y_cnt) : y_cnt;
    err_now = armed & ((en_ev.trail & (x_cnt != HTOT_W'(H_ACTIVE))) |
                       (en_ev.level & vs_ev.level) |
                       (vs_ev.lead & (lines != PIX_W'(V_ACTIVE))));
  end

  // Pixel coordinates, geometry measurement and registered event pulses.
  always_ff @(posedge in_9mhz_clk) begin
    if (in_rst) begin
      x_cnt       <= '0;
      h_cnt       <= '0;
      y_cnt       <= '0;
      armed       <= 1'b0;
      out_valid   <= 1'b0;
      out_pixelx  <= '0;
      out_pixely  <= '0;
      out_sof     <= 1'b0;
      out_err     <= 1'b0;
      out_h_total <= '0;
      out_v_total <= '0;
    end else begin
      out_valid  <= en_ev.level;
      out_pixelx <= en_ev.level ?
                    ((|col[HTOT_W-1:PIX_W]) ? '1 : col[PIX_W-1:0]) : '0;
      out_pixely <= en_ev.level ? y_cnt : '0;
      if (en_ev.level) x_cnt <= sat_inc_h(col);
      // vsync restarts the row even if a line ended in the same cycle
      y_cnt <= vs_ev.lead ? '0 : lines;
      h_cnt <= hs_ev.lead ? '0 : sat_inc_h(h_cnt);
      if (hs_ev.lead) out_h_total <= sat_inc_h(h_cnt);
      if (vs_ev.lead) begin
        out_v_total <= lines;
        armed       <= 1'b1;
      end
      out_sof <= vs_ev.lead;
      out_err <= err_now;
    end
  end

  // Lock tracking: wait for a frame start, count clean frames, drop on error.
  always_ff @(posedge in_9mhz_clk) begin
    if (in_rst) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      out_locked <= 1'b0;
    end else begin
      out_locked <= (state == LOCKED);
      case (state)
        SEARCH: begin
          if (vs_ev.lead) begin
            state    <= ALIGN;
            good_cnt <= '0;
          end
        end
        ALIGN: begin
          if (err_now) begin
            state <= SEARCH;
          end else if (vs_ev.lead) begin
            good_cnt <= good_cnt + 1'b1;
            if (int'(good_cnt) + 1 >= LOCK_FRAMES) state <= LOCKED;
          end
        end
        LOCKED: begin
          if (err_now) state <= SEARCH;
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef TFT_SYNC_DECODER_STATS_EN
  // Saturating counts of frame starts and error pulses.
  always_ff @(posedge in_9mhz_clk) begin
    if (in_rst) begin
      out_frame_cnt <= '0;
      out_err_cnt   <= '0;
    end else begin
      if (vs_ev.lead && !(&out_frame_cnt)) out_frame_cnt <= out_frame_cnt + 1'b1;
      if (err_now && !(&out_err_cnt)) out_err_cnt <= out_err_cnt + 1'b1;
    end
  end
`endif

endmodule
